instruction_window_rs: RTL and testbench
========================================

Name: instruction_window_rs

Overview:
- Parametrised successor of the 4-entry instruction queue / reservation station.
- Holds DEPTH decoded instructions (opcode, src1, src2, dest) and exposes the whole window to the DAG builder and scheduler.
- Accepts one instruction per cycle through a valid/ready handshake; retires any subset of entries per cycle from a scheduler mask.
- Adds what the previous block lacked: per-entry age ordering (oldest-entry output), global flush, popcount-correct occupancy and a dropped-enqueue indication.

Parameters:
- DEPTH, 8, number of window entries; 2..16.
- OP_W, 2, opcode field width.
- REG_W, 2, width of each register field (src1, src2, dest).
- INSTR_W, OP_W+3*REG_W, packed instruction width; derived, never overridden.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enq_valid  in  1  an instruction is offered this cycle.
- enq_ready  out  1  window can accept; equals !full.
- enq_instr  in  INSTR_W  packed {opcode, src1, src2, dest}, MSB first.
- retire_mask  in  DEPTH  bit i retires entry i.
- flush  in  1  invalidate all entries.
- instr_flat_out  out  DEPTH*INSTR_W  entry i occupies bits [i*INSTR_W +: INSTR_W].
- valid_bits  out  DEPTH  per-entry valid.
- oldest_onehot  out  DEPTH  one-hot of the oldest valid entry; all zero when empty.
- count  out  CNT_W  number of valid entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- enq_drop  out  1  registered one-cycle pulse: enq_valid was high while enq_ready was low.

Behaviour:
- Reset (asynchronous, active-high): all valid bits, stored fields, age matrix, count and enq_drop go to 0.
  - Outputs after reset: instr_flat_out=0, valid_bits=0, oldest_onehot=0, count=0, full=0, empty=1, enq_ready=1.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Storage: per-entry fields, a valid bit and an age matrix older[i][j], where 1 means entry i was enqueued before entry j. All registered.
- Retire: effective retire set = retire_mask & valid.
  - Bits set for invalid entries are ignored and do not change count.
  - Retired entries become invalid at the clock edge.
  - Stored fields are left as they were; no clearing required.
- Enqueue: a transfer occurs when enq_valid && enq_ready.
  - The entry is written into the lowest-index slot that is invalid at the start of the cycle.
  - A slot being retired in the same cycle is not reusable until the next cycle.
  - enq_ready is combinational from the current valid bits only; it never depends on retire_mask.
- Age update on enqueue into slot k:
  - older[k][j]=0 for all j.
  - older[j][k]=valid[j] && !retiring[j] for all j≠k.
  - The new entry is the youngest.
- oldest_onehot: bit i=1 iff valid[i] and no valid j has older[j][i]=1. Combinational from registered state; exactly one bit is set when non-empty.
- count next value = count − popcount(retire_mask & valid) + (transfer ? 1 : 0). Never underflows or overflows.
- Simultaneous retire and enqueue while full: no transfer. enq_drop pulses if enq_valid was high. Count decreases by the number retired.
- flush: has priority over retire and enqueue in the same cycle.
  - Clears all valid bits and the age matrix; count becomes 0.
  - enq_drop becomes 0 for that cycle; an enqueue offered in the flush cycle is lost silently.
- Latency: an accepted instruction appears in valid_bits / instr_flat_out on the cycle after the accepting edge.
- No combinational path from any input to any output except enq_valid→nothing; enq_ready depends on state only.

Test Plan:
- Reset with DEPTH=8, then enqueue 0x11,0x22,…,0x88 on consecutive cycles -> slots 0..7 filled in order; full=1, enq_ready=0, count=8, oldest_onehot=0x01.
- While full, assert enq_valid with 0x99 -> enq_drop=1 for one cycle; contents unchanged.
- Retire mask 0x05 on a full window -> valid_bits=0xFA, count=6, oldest_onehot=0x02. Then enqueue 0xAA -> written to slot 0; oldest_onehot stays 0x02; slot 0 is youngest.
- With valid_bits=0x0F and count=4, retire mask 0xF0 -> no change, count=4 (invalid bits ignored). Retire mask 0x01 plus enqueue in the same cycle -> new entry goes to slot 4, count=4, valid_bits=0x1E.
- Flush asserted together with enqueue and retire on a window holding 5 entries -> next cycle valid_bits=0, count=0, empty=1, oldest_onehot=0, enq_drop=0.
- Assert reset asynchronously between clock edges with 3 valid entries -> outputs reach reset values before the next edge; the first enqueue after deassertion lands in slot 0.

Source files
------------

// File: rtl/instruction_window_rs.sv
// Instruction window / reservation station: DEPTH entries, age-ordered, whole window exposed.
// Latency: an accepted enqueue is visible one cycle after the accepting edge; retire and flush take effect at the edge.
// Backpressure: enq_ready = !full, taken from registered state only; an offer while full is dropped and flagged on enq_drop.
module instruction_window_rs #(
  parameter int DEPTH = 8,
  parameter int OP_W  = 2,
  parameter int REG_W = 2,
  parameter int CNT_W = $clog2(DEPTH + 1),
  localparam int INSTR_W = OP_W + 3 * REG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [INSTR_W-1:0]         enq_instr,
  input  logic [DEPTH-1:0]           retire_mask,
  input  logic                       flush,
  output logic [DEPTH*INSTR_W-1:0]   instr_flat_out,
  output logic [DEPTH-1:0]           valid_bits,
  output logic [DEPTH-1:0]           oldest_onehot,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic                       empty,
  output logic                       enq_drop
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // older_q[i][j] = 1 means entry i was enqueued before entry j
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];
  logic [DEPTH-1:0]   older_q [DEPTH];
  logic [DEPTH-1:0]   older_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               enq_drop_q, enq_drop_d;

  logic [DEPTH-1:0]   retiring;
  logic [CNT_W-1:0]   ret_cnt;
  logic [IDX_W-1:0]   free_idx;
  logic               transfer;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ready = !full;
  assign transfer  = enq_valid && enq_ready;
  assign valid_bits = valid_q;
  assign count      = count_q;
  assign enq_drop   = enq_drop_q;

  // Effective retire set, its popcount, and the lowest slot free at the start of the cycle
  always_comb begin
    retiring = retire_mask & valid_q;
    ret_cnt  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ret_cnt = ret_cnt + CNT_W'(retiring[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Next state: retire, then enqueue into the free slot as the youngest entry; flush overrides everything
  always_comb begin
    valid_d    = valid_q & ~retiring;
    instr_d    = instr_q;
    older_d    = older_q;
    count_d    = count_q - ret_cnt;
    enq_drop_d = enq_valid && !enq_ready;
    if (transfer) begin
      valid_d[free_idx] = 1'b1;
      instr_d[free_idx] = enq_instr;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) older_d[j][free_idx] = valid_q[j] && !retiring[j];
      end
      count_d = count_d + CNT_W'(1);
    end
    if (flush) begin
      valid_d    = '0;
      instr_d    = instr_q;
      count_d    = '0;
      enq_drop_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end
  end

  // Oldest entry: valid and not preceded by any other valid entry
  always_comb begin
    oldest_onehot = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j] && older_q[j][i]) oldest_onehot[i] = 1'b0;
      end
    end
  end

  // Flatten the stored entries, entry i at bits [i*INSTR_W +: INSTR_W]
  always_comb begin
    instr_flat_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      instr_flat_out[i*INSTR_W +: INSTR_W] = instr_q[i];
    end
  end

  // State registers; reset discards everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      count_q    <= '0;
      enq_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      enq_drop_q <= enq_drop_d;
      instr_q    <= instr_d;
      older_q    <= older_d;
    end
  end

endmodule

// File: tb/tb_instruction_window_rs.sv
// Directed bench for instruction_window_rs (DEPTH=8): reference model with an age list,
// expected outputs queued when a cycle is driven and compared after the clock edge.
module tb_instruction_window_rs;

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [7:0]  enq_instr;
  logic [7:0]  retire_mask;
  logic        flush;
  logic [63:0] instr_flat_out;
  logic [7:0]  valid_bits;
  logic [7:0]  oldest_onehot;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        enq_drop;

  instruction_window_rs dut (
    .clk            (clk),
    .reset          (reset),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_instr      (enq_instr),
    .retire_mask    (retire_mask),
    .flush          (flush),
    .instr_flat_out (instr_flat_out),
    .valid_bits     (valid_bits),
    .oldest_onehot  (oldest_onehot),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .enq_drop       (enq_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  valid;
    logic [3:0]  cnt;
    logic [7:0]  oldest;
    logic        drop;
    logic [63:0] flat;
    logic [63:0] fmask;
  } exp_t;

  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: valid bits, stored fields, count and an age-ordered slot list
  logic [7:0] m_instr [8];
  logic [7:0] m_valid;
  logic [3:0] m_count;
  int         ageq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_count = '0;
    ageq.delete();
    for (int i = 0; i < 8; i++) m_instr[i] = '0;
  endtask

  task automatic compare_next(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, " valid"},  {56'd0, valid_bits}, {56'd0, e.valid});
      chk({tag, " count"},  {60'd0, count}, {60'd0, e.cnt});
      chk({tag, " oldest"}, {56'd0, oldest_onehot}, {56'd0, e.oldest});
      chk({tag, " drop"},   {63'd0, enq_drop}, {63'd0, e.drop});
      chk({tag, " full"},   {63'd0, full}, {63'd0, (e.cnt == 4'd8)});
      chk({tag, " empty"},  {63'd0, empty}, {63'd0, (e.cnt == 4'd0)});
      chk({tag, " ready"},  {63'd0, enq_ready}, {63'd0, (e.cnt != 4'd8)});
      chk({tag, " data"},   instr_flat_out & e.fmask, e.flat & e.fmask);
    end
  endtask

  // One clock: drive at negedge, predict, push, then compare just after the rising edge
  task automatic cycle(input string tag, input logic ev, input logic [7:0] ins,
                       input logic [7:0] rm, input logic fl);
    exp_t       e;
    logic       ready;
    logic       xfer;
    logic [7:0] ret;
    int         slot;
    @(negedge clk);
    enq_valid   = ev;
    enq_instr   = ins;
    retire_mask = rm;
    flush       = fl;
    ready = (m_count != 4'd8);
    ret   = rm & m_valid;
    xfer  = ev && ready && !fl;
    slot  = 0;
    for (int i = 7; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (fl) begin
      m_valid = '0;
      m_count = '0;
      ageq.delete();
      e.drop = 1'b0;
    end else begin
      for (int k = ageq.size() - 1; k >= 0; k--) if (ret[ageq[k]]) ageq.delete(k);
      m_valid = m_valid & ~ret;
      m_count = m_count - 4'($countones(ret));
      if (xfer) begin
        m_valid[slot] = 1'b1;
        m_instr[slot] = ins;
        ageq.push_back(slot);
        m_count = m_count + 4'd1;
      end
      e.drop = ev && !ready;
    end
    e.valid  = m_valid;
    e.cnt    = m_count;
    e.oldest = (ageq.size() > 0) ? (8'd1 << ageq[0]) : 8'd0;
    for (int i = 0; i < 8; i++) begin
      e.flat[i*8 +: 8]  = m_instr[i];
      e.fmask[i*8 +: 8] = {8{m_valid[i]}};
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare_next(tag);
    enq_valid   = 1'b0;
    enq_instr   = '0;
    retire_mask = '0;
    flush       = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enq_valid   = 1'b0;
    enq_instr   = '0;
    retire_mask = '0;
    flush       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst flat",   instr_flat_out, 64'd0);
    chk("rst valid",  {56'd0, valid_bits}, 64'd0);
    chk("rst oldest", {56'd0, oldest_onehot}, 64'd0);
    chk("rst count",  {60'd0, count}, 64'd0);
    chk("rst full",   {63'd0, full}, 64'd0);
    chk("rst empty",  {63'd0, empty}, 64'd1);
    chk("rst ready",  {63'd0, enq_ready}, 64'd1);
    chk("rst drop",   {63'd0, enq_drop}, 64'd0);
    reset = 1'b0;

    // Fill the window in order
    for (int i = 1; i <= 8; i++) begin
      cycle("fill", 1'b1, 8'(i * 8'h11), 8'h00, 1'b0);
    end
    chk("fill full",   {63'd0, full}, 64'd1);
    chk("fill ready",  {63'd0, enq_ready}, 64'd0);
    chk("fill count",  {60'd0, count}, 64'd8);
    chk("fill oldest", {56'd0, oldest_onehot}, 64'h01);
    chk("fill data",   instr_flat_out, 64'h8877665544332211);

    // Offer while full: dropped, one-cycle pulse
    cycle("drop", 1'b1, 8'h99, 8'h00, 1'b0);
    chk("drop pulse", {63'd0, enq_drop}, 64'd1);
    chk("drop data",  instr_flat_out, 64'h8877665544332211);
    cycle("drop_end", 1'b0, 8'h00, 8'h00, 1'b0);
    chk("drop clear", {63'd0, enq_drop}, 64'd0);

    // Retire 0 and 2, then refill slot 0 as the youngest
    cycle("ret05", 1'b0, 8'h00, 8'h05, 1'b0);
    chk("ret05 valid",  {56'd0, valid_bits}, 64'hFA);
    chk("ret05 count",  {60'd0, count}, 64'd6);
    chk("ret05 oldest", {56'd0, oldest_onehot}, 64'h02);
    cycle("enqAA", 1'b1, 8'hAA, 8'h00, 1'b0);
    chk("enqAA slot0",  {56'd0, instr_flat_out[7:0]}, 64'hAA);
    chk("enqAA oldest", {56'd0, oldest_onehot}, 64'h02);
    cycle("ret_rest", 1'b0, 8'h00, 8'hFE, 1'b0);
    chk("slot0 youngest", {56'd0, oldest_onehot}, 64'h01);

    // Build 0x0F, ignore retire bits of invalid entries, retire+enqueue same cycle
    cycle("flush1", 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle("fill4", 1'b1, 8'(8'hB0 + i), 8'h00, 1'b0);
    end
    cycle("retF0", 1'b0, 8'h00, 8'hF0, 1'b0);
    chk("retF0 count", {60'd0, count}, 64'd4);
    cycle("ret_enq", 1'b1, 8'hC1, 8'h01, 1'b0);
    chk("ret_enq valid", {56'd0, valid_bits}, 64'h1E);
    chk("ret_enq count", {60'd0, count}, 64'd4);
    chk("ret_enq slot4", {56'd0, instr_flat_out[39:32]}, 64'hC1);
    cycle("enqC2", 1'b1, 8'hC2, 8'h00, 1'b0);

    // Flush beats retire and enqueue on a 5-entry window
    chk("pre_flush count", {60'd0, count}, 64'd5);
    cycle("flush2", 1'b1, 8'hD1, 8'h03, 1'b1);
    chk("flush valid",  {56'd0, valid_bits}, 64'd0);
    chk("flush empty",  {63'd0, empty}, 64'd1);
    chk("flush oldest", {56'd0, oldest_onehot}, 64'd0);
    chk("flush drop",   {63'd0, enq_drop}, 64'd0);

    // Asynchronous reset between edges with 3 valid entries
    for (int i = 0; i < 3; i++) begin
      cycle("fill3", 1'b1, 8'(8'hE0 + i), 8'h00, 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst valid",  {56'd0, valid_bits}, 64'd0);
    chk("arst count",  {60'd0, count}, 64'd0);
    chk("arst empty",  {63'd0, empty}, 64'd1);
    chk("arst ready",  {63'd0, enq_ready}, 64'd1);
    chk("arst oldest", {56'd0, oldest_onehot}, 64'd0);
    chk("arst flat",   instr_flat_out, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst", 1'b1, 8'h5A, 8'h00, 1'b0);
    chk("post_rst valid", {56'd0, valid_bits}, 64'h01);
    chk("post_rst slot0", {56'd0, instr_flat_out[7:0]}, 64'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
